// File: rtl/exec_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// exec_ctrl_pkg
// Shared definitions for the run-control sequencer and the core decode:
//   - state_t      : sequencer state encodings (HALT/RUN/STEP/DONE)
//   - END_* consts : field positions of the end-of-program instruction
//                    (jump flag bit, 8-bit self-jump offset)
//   - is_end_instr : decodes "unconditional jump to self"
// ----------------------------------------------------------------------------
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int END_JMP_BIT = 31;
    localparam int END_OFS_MSB = 7;
    localparam int END_OFS_LSB = 0;

    // A jump with zero offset never leaves its own PC, so the program is over.
    function automatic logic is_end_instr(input logic [31:0] instr);
        return instr[END_JMP_BIT] && (instr[END_OFS_MSB:END_OFS_LSB] == 8'h00);
    endfunction

endpackage

// File: rtl/exec_ctrl_rise_edge.sv
// ----------------------------------------------------------------------------
// rise_edge
// Registered rising-edge detector for a level input (used on the step button).
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (clears the history register)
//   i_d    : level input
//   o_rise : high for the cycle in which i_d is 1 and was 0 last cycle
// ----------------------------------------------------------------------------
module rise_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/exec_ctrl.sv
// ----------------------------------------------------------------------------
// exec_ctrl
// Run-control sequencer for the single-cycle core. Every clock it decides
// whether the core commits the current instruction (PC update + RF write).
// Supports free-run, single-step, external halt, one PC breakpoint,
// end-of-program detection and an optional retire limit.
// Parameters:
//   RETIRE_W : width of the retired-instruction counter
//   LIMIT    : max instructions to retire, 0 = unlimited
// Ports:
//   clk_i      : system clock
//   reset      : synchronous active-high reset
//   run_i      : level, request free-run
//   step_i     : level from button, each rising edge requests one instruction
//   halt_i     : level, forces halt (highest priority)
//   bp_en_i    : breakpoint enable
//   bp_addr_i  : breakpoint PC (byte address)
//   pc_i       : current PC of the core
//   instr_i    : instruction fetched at pc_i
//   exec_en_o  : commit enable (combinational, sampled by the core next edge)
//   state_o    : current state encoding
//   retired_o  : committed-instruction count, saturating
// ----------------------------------------------------------------------------
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32,
    parameter int LIMIT    = 0
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic                run_i,
    input  logic                step_i,
    input  logic                halt_i,
    input  logic                bp_en_i,
    input  logic [31:0]         bp_addr_i,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         instr_i,
    output logic                exec_en_o,
    output logic [1:0]          state_o,
    output logic [RETIRE_W-1:0] retired_o
);

    state_t              r_state;
    state_t              w_next;
    logic                r_resume;
    logic [RETIRE_W-1:0] r_retired;

    logic w_step_edge;
    logic w_end;
    logic w_limit;
    logic w_bp;
    logic w_en;

    rise_edge u_step_edge (
        .i_clk  (clk_i),
        .i_rst  (reset),
        .i_d    (step_i),
        .o_rise (w_step_edge)
    );

    assign w_end   = is_end_instr(instr_i);
    assign w_limit = (LIMIT != 0) && (r_retired == RETIRE_W'(LIMIT));
    // r_resume masks the breakpoint for the first RUN cycle after leaving
    // HALT, so a resume from a breakpoint commits the instruction at that PC.
    assign w_bp    = bp_en_i && (pc_i == bp_addr_i) && !r_resume;

    always_comb begin
        w_next = r_state;
        w_en   = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (halt_i) begin
                    w_next = ST_HALT;
                end else if (w_step_edge) begin
                    w_next = (w_end || w_limit) ? ST_DONE : ST_STEP;
                end else if (run_i) begin
                    w_next = ST_RUN;
                end
            end
            ST_STEP: begin
                // Unconditional: neither halt nor breakpoint cancels a step.
                w_en   = 1'b1;
                w_next = ST_HALT;
            end
            ST_RUN: begin
                if (halt_i) begin
                    w_next = ST_HALT;
                end else if (w_end || w_limit) begin
                    w_next = ST_DONE;
                end else if (w_bp || !run_i) begin
                    w_next = ST_HALT;
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_DONE;
            end
            default: begin
                w_next = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_resume <= 1'b0;
        end else if (r_state == ST_HALT && w_next == ST_RUN) begin
            r_resume <= 1'b1;
        end else if (r_state == ST_RUN) begin
            r_resume <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_en && (r_retired != '1)) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign exec_en_o = w_en;
    assign state_o   = r_state;
    assign retired_o = r_retired;

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        t_reset = 1'b1;
    logic        t_run = 1'b0;
    logic        t_step = 1'b0;
    logic        t_halt = 1'b0;
    logic        t_bp_en = 1'b0;
    logic [31:0] t_bp_addr = 32'h0;
    logic [31:0] t_pc = 32'h0;
    logic [31:0] t_instr = 32'h0;

    logic        m_en,  l_en,  s_en;
    logic [1:0]  m_st,  l_st,  s_st;
    logic [31:0] m_ret, l_ret;
    logic [2:0]  s_ret;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          sel;
        logic [63:0] tag;
        logic        en;
        logic [1:0]  st;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    always #5 clk = ~clk;

    exec_ctrl #(.RETIRE_W(32), .LIMIT(0)) u_main (
        .clk_i(clk), .reset(t_reset), .run_i(t_run), .step_i(t_step), .halt_i(t_halt),
        .bp_en_i(t_bp_en), .bp_addr_i(t_bp_addr), .pc_i(t_pc), .instr_i(t_instr),
        .exec_en_o(m_en), .state_o(m_st), .retired_o(m_ret)
    );

    exec_ctrl #(.RETIRE_W(32), .LIMIT(5)) u_lim (
        .clk_i(clk), .reset(t_reset), .run_i(t_run), .step_i(t_step), .halt_i(t_halt),
        .bp_en_i(t_bp_en), .bp_addr_i(t_bp_addr), .pc_i(t_pc), .instr_i(t_instr),
        .exec_en_o(l_en), .state_o(l_st), .retired_o(l_ret)
    );

    exec_ctrl #(.RETIRE_W(3), .LIMIT(0)) u_sat (
        .clk_i(clk), .reset(t_reset), .run_i(t_run), .step_i(t_step), .halt_i(t_halt),
        .bp_en_i(t_bp_en), .bp_addr_i(t_bp_addr), .pc_i(t_pc), .instr_i(t_instr),
        .exec_en_o(s_en), .state_o(s_st), .retired_o(s_ret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Pop one expectation per cycle and compare on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            case (m_e.sel)
                0: begin
                    chk($sformatf("%s.en", m_e.tag), {31'b0, m_en}, {31'b0, m_e.en});
                    chk($sformatf("%s.st", m_e.tag), {30'b0, m_st}, {30'b0, m_e.st});
                    chk($sformatf("%s.ret", m_e.tag), m_ret, m_e.ret);
                end
                1: begin
                    chk($sformatf("%s.en", m_e.tag), {31'b0, l_en}, {31'b0, m_e.en});
                    chk($sformatf("%s.st", m_e.tag), {30'b0, l_st}, {30'b0, m_e.st});
                    chk($sformatf("%s.ret", m_e.tag), l_ret, m_e.ret);
                end
                default: begin
                    chk($sformatf("%s.en", m_e.tag), {31'b0, s_en}, {31'b0, m_e.en});
                    chk($sformatf("%s.st", m_e.tag), {30'b0, s_st}, {30'b0, m_e.st});
                    chk($sformatf("%s.ret", m_e.tag), {29'b0, s_ret}, m_e.ret);
                end
            endcase
        end
    end

    // Drive one cycle of inputs and push what the selected DUT must show.
    task automatic cyc(input logic [63:0] tag, input int sel,
                       input logic r, input logic s, input logic h,
                       input logic ee, input logic [1:0] es, input logic [31:0] er);
        exp_t e;
        t_run  = r;
        t_step = s;
        t_halt = h;
        e.sel = sel;
        e.tag = tag;
        e.en  = ee;
        e.st  = es;
        e.ret = er;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        t_reset = 1'b1;
        t_run   = 1'b0;
        t_step  = 1'b0;
        t_halt  = 1'b0;
        @(posedge clk);
        #1;
        t_reset = 1'b0;
    endtask

    initial begin
        int r;
        repeat (2) @(posedge clk);
        #1;
        t_reset = 1'b0;

        // free run for 10 cycles; a step edge while running is dropped
        cyc("rst", 0, 0, 0, 0, 0, 2'b00, 0);
        cyc("run0", 0, 1, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 10; i++) cyc("run", 0, 1, (i == 4), 0, 1, 2'b01, i);
        cyc("runstop", 0, 0, 0, 0, 0, 2'b01, 10);
        cyc("idle", 0, 0, 0, 0, 0, 2'b00, 10);
        cyc("idle", 0, 0, 0, 0, 0, 2'b00, 10);
        // halt and step edge together in HALT: stay
        cyc("hs", 0, 0, 1, 1, 0, 2'b00, 10);
        cyc("hs2", 0, 0, 0, 0, 0, 2'b00, 10);
        cyc("hs3", 0, 0, 0, 0, 0, 2'b00, 10);

        // three single steps; halt during the last STEP does not cancel it
        do_reset();
        r = 0;
        for (int p = 0; p < 3; p++) begin
            cyc("stp0", 0, 0, 1, 0, 0, 2'b00, r);
            cyc("stp1", 0, 0, 1, (p == 2), 1, 2'b10, r);
            cyc("stp2", 0, 0, 0, (p == 2), 0, 2'b00, r + 1);
            cyc("stp3", 0, 0, 0, 0, 0, 2'b00, r + 1);
            r++;
        end

        // breakpoint at 0x10, then resume past it
        do_reset();
        t_bp_en = 1'b1;
        t_bp_addr = 32'h10;
        t_pc = 32'h0;
        cyc("bp0", 0, 1, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            t_pc = 32'(4 * i);
            cyc("bprun", 0, 1, 0, 0, 1, 2'b01, i);
        end
        t_pc = 32'h10;
        cyc("bphit", 0, 1, 0, 0, 0, 2'b01, 4);
        cyc("bphalt", 0, 0, 0, 0, 0, 2'b00, 4);
        cyc("bpres0", 0, 1, 0, 0, 0, 2'b00, 4);
        cyc("bpres", 0, 1, 0, 0, 1, 2'b01, 4);
        t_pc = 32'h14;
        cyc("bpnext", 0, 1, 0, 0, 1, 2'b01, 5);
        t_pc = 32'h18;
        cyc("bpstop", 0, 0, 0, 0, 0, 2'b01, 6);
        t_bp_en = 1'b0;
        t_pc = 32'h0;

        // end-of-program while running; DONE ignores everything but reset
        do_reset();
        cyc("e0", 0, 1, 0, 0, 0, 2'b00, 0);
        t_instr = 32'h8000_0004;
        cyc("e_nz", 0, 1, 0, 0, 1, 2'b01, 0);
        t_instr = 32'h8000_0000;
        cyc("end", 0, 1, 0, 0, 0, 2'b01, 1);
        cyc("done1", 0, 1, 1, 0, 0, 2'b11, 1);
        cyc("done2", 0, 0, 0, 1, 0, 2'b11, 1);
        cyc("done3", 0, 1, 0, 0, 0, 2'b11, 1);
        t_instr = 32'h0;
        do_reset();
        cyc("rst2", 0, 0, 0, 0, 0, 2'b00, 0);
        // step edge onto an end instruction goes straight to DONE
        t_instr = 32'h8000_0000;
        cyc("send", 0, 0, 1, 0, 0, 2'b00, 0);
        t_instr = 32'h0;
        cyc("sdone", 0, 0, 0, 0, 0, 2'b11, 0);

        // retire limit of 5
        do_reset();
        cyc("l0", 1, 1, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) cyc("lrun", 1, 1, 0, 0, 1, 2'b01, i);
        cyc("lhit", 1, 1, 0, 0, 0, 2'b01, 5);
        cyc("ldone", 1, 1, 0, 0, 0, 2'b11, 5);
        cyc("ldone", 1, 1, 0, 0, 0, 2'b11, 5);

        // halt mid-run, resume, then reset mid-run
        do_reset();
        cyc("h0", 0, 1, 0, 0, 0, 2'b00, 0);
        cyc("hr", 0, 1, 0, 0, 1, 2'b01, 0);
        cyc("hr", 0, 1, 0, 0, 1, 2'b01, 1);
        cyc("hmid", 0, 1, 0, 1, 0, 2'b01, 2);
        cyc("hhold", 0, 1, 0, 1, 0, 2'b00, 2);
        cyc("hres0", 0, 1, 0, 0, 0, 2'b00, 2);
        cyc("hres", 0, 1, 0, 0, 1, 2'b01, 2);
        t_reset = 1'b1;
        t_run = 1'b1;
        @(posedge clk);
        #1;
        t_reset = 1'b0;
        cyc("rstmid", 0, 1, 0, 0, 0, 2'b00, 0);
        cyc("rstrun", 0, 0, 0, 0, 0, 2'b01, 0);

        // counter saturation on a 3-bit instance
        do_reset();
        cyc("s0", 2, 1, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 10; i++) cyc("sat", 2, 1, 0, 0, 1, 2'b01, (i > 7) ? 7 : i);
        cyc("sstop", 2, 0, 0, 0, 0, 2'b01, 7);

        @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
